// File: rtl/frame_sequencer.sv
// Game-loop frame controller: sequences clear, update, draw and FPS-limit stages
// through start/finished handshakes, counts frames and traps hung stages.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | between frames; waits for run or a step pulse
// CLR_GO   | clear_start pulse
// CLR_WAIT | wait for clear_finished (first cycle is a guard)
// UPD_GO   | update_start pulse
// UPD_WAIT | wait for update_finished
// DRW_GO   | draw_start pulse
// DRW_WAIT | wait for draw_finished
// LIM_GO   | limit_start pulse
// LIM_WAIT | wait for limit_finished, then count the frame
// FAULT    | a stage timed out; only reset leaves
module frame_sequencer #(
  parameter int                     DELAY_WIDTH   = 26,
  parameter logic [DELAY_WIDTH-1:0] DELAY_0       = 26'd833333,
  parameter logic [DELAY_WIDTH-1:0] DELAY_1       = 26'd1666666,
  parameter logic [DELAY_WIDTH-1:0] DELAY_2       = 26'd208333,
  parameter logic [DELAY_WIDTH-1:0] DELAY_3       = 26'd0,
  parameter int                     FRAME_WIDTH   = 16,
  parameter int                     TIMEOUT_WIDTH = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic [1:0]             speed_sel,
  input  logic                   clear_finished,
  input  logic                   update_finished,
  input  logic                   draw_finished,
  input  logic                   limit_finished,
  output logic                   clear_start,
  output logic                   update_start,
  output logic                   draw_start,
  output logic                   limit_start,
  output logic [DELAY_WIDTH-1:0] limit_delay,
  output logic [FRAME_WIDTH-1:0] frame_count,
  output logic                   busy,
  output logic                   fault,
  output logic [3:0]             state_dbg
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] CLR_GO   = 4'd1;
  localparam logic [3:0] CLR_WAIT = 4'd2;
  localparam logic [3:0] UPD_GO   = 4'd3;
  localparam logic [3:0] UPD_WAIT = 4'd4;
  localparam logic [3:0] DRW_GO   = 4'd5;
  localparam logic [3:0] DRW_WAIT = 4'd6;
  localparam logic [3:0] LIM_GO   = 4'd7;
  localparam logic [3:0] LIM_WAIT = 4'd8;
  localparam logic [3:0] FAULT    = 4'd9;

  // Trip one count early so the watchdog value reaches all-ones as FAULT is entered.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  logic [3:0]               state;
  logic [3:0]               state_nxt;
  logic [TIMEOUT_WIDTH-1:0] wd;
  logic                     stage_fin;
  logic                     in_wait;
  logic [DELAY_WIDTH-1:0]   preset;

  assign state_dbg = state;
  assign in_wait   = (state == CLR_WAIT) || (state == UPD_WAIT) ||
                     (state == DRW_WAIT) || (state == LIM_WAIT);

  always_comb begin
    stage_fin = 1'b0;
    case (state)
      CLR_WAIT: stage_fin = clear_finished;
      UPD_WAIT: stage_fin = update_finished;
      DRW_WAIT: stage_fin = draw_finished;
      LIM_WAIT: stage_fin = limit_finished;
      default:  stage_fin = 1'b0;
    endcase
  end

  always_comb begin
    preset = DELAY_0;
    case (speed_sel)
      2'd0:    preset = DELAY_0;
      2'd1:    preset = DELAY_1;
      2'd2:    preset = DELAY_2;
      default: preset = DELAY_3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (run || step) state_nxt = CLR_GO;
      CLR_GO,
      UPD_GO,
      DRW_GO,
      LIM_GO:   state_nxt = state + 4'd1;
      CLR_WAIT,
      UPD_WAIT,
      DRW_WAIT,
      LIM_WAIT: begin
        // wd==0 marks the guard cycle; finished beats a coincident timeout
        if ((wd != '0) && stage_fin)
          state_nxt = (state == LIM_WAIT) ? IDLE : state + 4'd1;
        else if (wd == WD_LAST)
          state_nxt = FAULT;
      end
      FAULT:    state_nxt = FAULT;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wd           <= '0;
      clear_start  <= 1'b0;
      update_start <= 1'b0;
      draw_start   <= 1'b0;
      limit_start  <= 1'b0;
      limit_delay  <= DELAY_0;
      frame_count  <= '0;
      busy         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nxt;
      wd           <= in_wait ? wd + TIMEOUT_WIDTH'(1) : '0;
      clear_start  <= (state_nxt == CLR_GO);
      update_start <= (state_nxt == UPD_GO);
      draw_start   <= (state_nxt == DRW_GO);
      limit_start  <= (state_nxt == LIM_GO);
      busy         <= (state_nxt != IDLE);
      fault        <= (state_nxt == FAULT);
      if ((state == IDLE) && (state_nxt == CLR_GO))
        limit_delay <= preset;
      if ((state == LIM_WAIT) && (state_nxt == IDLE))
        frame_count <= frame_count + FRAME_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: one default instance and one with
// narrow watchdog/frame counter, each driven by latency-programmable stage stubs.
module tb_frame_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int tcyc     = 0;
  always @(posedge clock) tcyc <= tcyc + 1;

  // instance A: default parameters
  logic        run_a = 1'b0, step_a = 1'b0;
  logic [1:0]  spd_a = 2'd0;
  logic [3:0]  fin_a = 4'hf, st_a;
  logic [25:0] ld_a;
  logic [15:0] fc_a;
  logic        busy_a, fault_a;
  logic [3:0]  sd_a;
  int          lat_a [4] = '{3, 3, 3, 5};
  int          cnt_a [4] = '{0, 0, 0, 0};

  // instance B: TIMEOUT_WIDTH=4, FRAME_WIDTH=4
  logic        run_b = 1'b0, step_b = 1'b0;
  logic [1:0]  spd_b = 2'd0;
  logic [3:0]  fin_b = 4'hf, st_b;
  logic [25:0] ld_b;
  logic [3:0]  fc_b;
  logic        busy_b, fault_b;
  logic [3:0]  sd_b;
  int          lat_b [4] = '{0, 0, 0, 0};
  int          cnt_b [4] = '{0, 0, 0, 0};

  frame_sequencer dut_a (
    .clock(clock), .reset(reset), .run(run_a), .step(step_a), .speed_sel(spd_a),
    .clear_finished(fin_a[0]), .update_finished(fin_a[1]),
    .draw_finished(fin_a[2]), .limit_finished(fin_a[3]),
    .clear_start(st_a[0]), .update_start(st_a[1]), .draw_start(st_a[2]),
    .limit_start(st_a[3]), .limit_delay(ld_a), .frame_count(fc_a),
    .busy(busy_a), .fault(fault_a), .state_dbg(sd_a));

  frame_sequencer #(.FRAME_WIDTH(4), .TIMEOUT_WIDTH(4)) dut_b (
    .clock(clock), .reset(reset), .run(run_b), .step(step_b), .speed_sel(spd_b),
    .clear_finished(fin_b[0]), .update_finished(fin_b[1]),
    .draw_finished(fin_b[2]), .limit_finished(fin_b[3]),
    .clear_start(st_b[0]), .update_start(st_b[1]), .draw_start(st_b[2]),
    .limit_start(st_b[3]), .limit_delay(ld_b), .frame_count(fc_b),
    .busy(busy_b), .fault(fault_b), .state_dbg(sd_b));

  // Stage stubs: finished drops on the edge that samples start, rises lat edges later.
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (st_a[i]) begin
        fin_a[i] <= 1'b0;
        cnt_a[i] <= lat_a[i];
      end else if (!fin_a[i]) begin
        if (cnt_a[i] <= 1) fin_a[i] <= 1'b1;
        else cnt_a[i] <= cnt_a[i] - 1;
      end
      if (st_b[i]) begin
        fin_b[i] <= 1'b0;
        cnt_b[i] <= lat_b[i];
      end else if (!fin_b[i]) begin
        if (cnt_b[i] <= 1) fin_b[i] <= 1'b1;
        else cnt_b[i] <= cnt_b[i] - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for a start pulse, checks it is alone and lasts one cycle; returns its cycle.
  task automatic wait_a(input int idx, output int t);
    logic [3:0] expv;
    int c;
    c = 0;
    while (!st_a[idx] && c < 60) begin @(negedge clock); c++; end
    t = tcyc;
    expv = 4'b0001 << idx;
    chk($sformatf("a_start%0d_onehot", idx), 32'(st_a), 32'(expv));
    @(negedge clock);
    chk($sformatf("a_start%0d_width", idx), 32'(st_a[idx]), 32'd0);
  endtask

  task automatic wait_b(input int idx, output int t);
    logic [3:0] expv;
    int c;
    c = 0;
    while (!st_b[idx] && c < 60) begin @(negedge clock); c++; end
    t = tcyc;
    expv = 4'b0001 << idx;
    chk($sformatf("b_start%0d_onehot", idx), 32'(st_b), 32'(expv));
    @(negedge clock);
    chk($sformatf("b_start%0d_width", idx), 32'(st_b[idx]), 32'd0);
  endtask

  task automatic idle_a();
    int c;
    c = 0;
    while (busy_a && c < 60) begin @(negedge clock); c++; end
    chk("a_back_to_idle", 32'(busy_a), 32'd0);
  endtask

  task automatic idle_b();
    int c;
    c = 0;
    while (busy_b && c < 60) begin @(negedge clock); c++; end
    chk("b_back_to_idle", 32'(busy_b), 32'd0);
  endtask

  initial begin
    int t0, t1, t2, t3, tp, k, n;

    // reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_state", 32'(sd_a), 32'd0);
    chk("rst_starts", 32'(st_a), 32'd0);
    chk("rst_frame_count", 32'(fc_a), 32'd0);
    chk("rst_limit_delay", 32'(ld_a), 32'd833333);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_fault", 32'(fault_a), 32'd0);

    // continuous run, stage latency 3, limiter latency 5
    run_a = 1'b1;
    wait_a(0, t0);
    chk("run_fc0", 32'(fc_a), 32'd0);
    chk("run_delay0", 32'(ld_a), 32'd833333);
    chk("run_busy", 32'(busy_a), 32'd1);
    wait_a(1, t1); chk("gap_clr_upd", 32'(t1 - t0), 32'd5);
    wait_a(2, t2); chk("gap_upd_drw", 32'(t2 - t1), 32'd5);
    wait_a(3, t3); chk("gap_drw_lim", 32'(t3 - t2), 32'd5);
    wait_a(0, t0); chk("gap_lim_clr", 32'(t0 - t3), 32'd8);
    chk("run_fc1", 32'(fc_a), 32'd1);
    wait_a(1, t1); wait_a(2, t2); wait_a(3, t3);
    wait_a(0, t0); chk("run_fc2", 32'(fc_a), 32'd2);

    // reset for two cycles while in DRW_WAIT
    wait_a(1, t1); wait_a(2, t2);
    chk("in_drw_wait", 32'(sd_a), 32'd6);
    run_a = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_state", 32'(sd_a), 32'd0);
    chk("midrst_starts", 32'(st_a), 32'd0);
    chk("midrst_fc", 32'(fc_a), 32'd0);
    chk("midrst_delay", 32'(ld_a), 32'd833333);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    repeat (10) @(negedge clock);

    // single step; a second step pulse mid-frame must be ignored
    step_a = 1'b1; @(negedge clock); step_a = 1'b0;
    wait_a(0, t0); wait_a(1, t1);
    step_a = 1'b1; @(negedge clock); step_a = 1'b0;
    wait_a(2, t2); wait_a(3, t3);
    idle_a();
    chk("step_fc", 32'(fc_a), 32'd1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (busy_a || (st_a != 4'd0)) n++;
    end
    chk("step_stays_idle", 32'(n), 32'd0);

    // speed change mid-frame applies only to the next frame
    spd_a = 2'd2;
    step_a = 1'b1; @(negedge clock); step_a = 1'b0;
    wait_a(0, t0); chk("spd2_at_clr", 32'(ld_a), 32'd208333);
    wait_a(1, t1);
    spd_a = 2'd3;
    wait_a(2, t2); wait_a(3, t3);
    chk("spd2_at_lim", 32'(ld_a), 32'd208333);
    idle_a();
    chk("spd_fc2", 32'(fc_a), 32'd2);
    step_a = 1'b1; @(negedge clock); step_a = 1'b0;
    wait_a(0, t0); chk("spd3_next_frame", 32'(ld_a), 32'd0);
    wait_a(1, t1); wait_a(2, t2); wait_a(3, t3);
    idle_a();
    chk("spd_fc3", 32'(fc_a), 32'd3);

    // B: zero-latency stubs, 13-cycle frames, 4-bit frame counter wraps
    spd_b = 2'd3;
    run_b = 1'b1;
    wait_b(0, tp);
    for (int f = 1; f <= 16; f++) begin
      wait_b(0, t0);
      chk($sformatf("b_frame%0d_len", f), 32'(t0 - tp), 32'd13);
      tp = t0;
      if (f == 15) chk("b_fc15", 32'(fc_b), 32'd15);
    end
    chk("b_fc_wrap", 32'(fc_b), 32'd0);
    chk("b_delay3", 32'(ld_b), 32'd0);
    run_b = 1'b0;
    idle_b();
    chk("b_fc_after", 32'(fc_b), 32'd1);

    // B: draw finishes on the very edge the watchdog would trip -> no fault
    lat_b[2] = 14;
    step_b = 1'b1; @(negedge clock); step_b = 1'b0;
    wait_b(0, t0); wait_b(1, t1); wait_b(2, t2); wait_b(3, t3);
    idle_b();
    chk("b_edge_nofault", 32'(fault_b), 32'd0);
    chk("b_edge_fc", 32'(fc_b), 32'd2);

    // B: draw one cycle too late -> FAULT 15 cycles after DRW_WAIT entry
    lat_b[2] = 15;
    step_b = 1'b1; @(negedge clock); step_b = 1'b0;
    wait_b(0, t0); wait_b(1, t1); wait_b(2, t2);
    k = 1;
    while (sd_b != 4'd9 && k < 40) begin @(negedge clock); k++; end
    chk("b_fault_latency", 32'(k), 32'd16);
    chk("b_fault_flag", 32'(fault_b), 32'd1);
    chk("b_fault_busy", 32'(busy_b), 32'd1);
    run_b = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (st_b != 4'd0) n++;
    end
    chk("b_fault_no_starts", 32'(n), 32'd0);
    chk("b_fault_sticky", 32'(sd_b), 32'd9);
    run_b = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("b_fault_cleared", 32'(fault_b), 32'd0);
    chk("b_state_cleared", 32'(sd_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
